// File: rtl/load_extract_unit_pkg.sv
// Shared encodings for the load path: funct3 load opcodes, load-unit FSM states,
// and small helpers for decoding a request.
package load_extract_unit_pkg;

  localparam logic [2:0] FNC_LB  = 3'b000;
  localparam logic [2:0] FNC_LH  = 3'b001;
  localparam logic [2:0] FNC_LW  = 3'b010;
  localparam logic [2:0] FNC_LBU = 3'b100;
  localparam logic [2:0] FNC_LHU = 3'b101;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD0  = 3'd1;
  localparam logic [2:0] ST_RD1  = 3'd2;
  localparam logic [2:0] ST_CAP  = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

  function automatic logic fnc_legal(input logic [2:0] f);
    case (f)
      FNC_LB, FNC_LH, FNC_LW, FNC_LBU, FNC_LHU: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

  // A load crosses when its bytes spill past the end of the addressed word.
  function automatic logic fnc_crosses(input logic [2:0] f, input logic [1:0] off);
    case (f)
      FNC_LW:          return off != 2'd0;
      FNC_LH, FNC_LHU: return off == 2'd3;
      default:         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_extract_unit_align_ext.sv
// Combinational extract/extend: picks the addressed byte, halfword or word out of
// a two-word window and sign- or zero-extends it to 32 bits.
module load_align_ext
  import load_extract_unit_pkg::*;
(
  input  logic [63:0] data_in,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data_out
);

  logic [31:0] window;

  always_comb begin
    window = 32'(data_in >> {off, 3'b000});
    case (funct3)
      FNC_LB:  data_out = {{24{window[7]}}, window[7:0]};
      FNC_LBU: data_out = {24'h0, window[7:0]};
      FNC_LH:  data_out = {{16{window[15]}}, window[15:0]};
      FNC_LHU: data_out = {16'h0, window[15:0]};
      default: data_out = window;
    endcase
  end

endmodule

// File: rtl/load_extract_unit.sv
// Memory-stage load unit: issues one or two BRAM word reads per load, merges
// word-crossing loads and returns a registered, extended result.
//
// state | meaning
// IDLE  | ready for a request
// RD0   | first word read in flight; issue second read if crossing
// RD1   | capture low word, high word read in flight
// CAP   | extract/extend and register the response
// ERR   | one-cycle error response, no BRAM access
module load_extract_unit
  import load_extract_unit_pkg::*;
#(
  parameter int ADDR_W      = 14,
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic [2:0]        req_funct3,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_dout,
  output logic              resp_valid,
  output logic [31:0]       resp_data,
  output logic              resp_err,
  output logic              busy
);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] wa_q, wa_d;
  logic [1:0]        off_q, off_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              cross_q, cross_d;
  logic [31:0]       lo_q, lo_d;
  logic              mem_en_q, mem_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_data_q, resp_data_d;
  logic              resp_err_q, resp_err_d;

  logic              req_cross;
  logic [63:0]       merged;
  logic [31:0]       extracted;
  logic              unused_addr_hi;

  // Byte address bits above the BRAM's reach are ignored.
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  assign req_cross = fnc_crosses(req_funct3, req_addr[1:0]);
  assign merged    = cross_q ? {mem_dout, lo_q} : {32'h0, mem_dout};

  load_align_ext u_align (
    .data_in  (merged),
    .off      (off_q),
    .funct3   (funct3_q),
    .data_out (extracted)
  );

  always_comb begin
    state_d      = state_q;
    wa_d         = wa_q;
    off_d        = off_q;
    funct3_d     = funct3_q;
    cross_d      = cross_q;
    lo_d         = lo_q;
    mem_en_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    resp_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          wa_d     = req_addr[ADDR_W+1:2];
          off_d    = req_addr[1:0];
          funct3_d = req_funct3;
          cross_d  = req_cross;
          if (!fnc_legal(req_funct3) || (req_cross && !MISALIGN_EN)) begin
            state_d = ST_ERR;
          end else begin
            mem_en_d   = 1'b1;
            mem_addr_d = req_addr[ADDR_W+1:2];
            state_d    = ST_RD0;
          end
        end
      end
      ST_RD0: begin
        if (cross_q) begin
          mem_en_d   = 1'b1;
          mem_addr_d = wa_q + ADDR_W'(1);
          state_d    = ST_RD1;
        end else begin
          state_d = ST_CAP;
        end
      end
      ST_RD1: begin
        lo_d    = mem_dout;
        state_d = ST_CAP;
      end
      ST_CAP: begin
        resp_valid_d = 1'b1;
        resp_data_d  = extracted;
        state_d      = ST_IDLE;
      end
      ST_ERR: begin
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b1;
        resp_data_d  = 32'h0;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort wins over everything; the last response stays on resp_data.
    if (flush) begin
      state_d      = ST_IDLE;
      mem_en_d     = 1'b0;
      mem_addr_d   = mem_addr_q;
      resp_valid_d = 1'b0;
      resp_err_d   = 1'b0;
      resp_data_d  = resp_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      wa_q         <= '0;
      off_q        <= '0;
      funct3_q     <= '0;
      cross_q      <= 1'b0;
      lo_q         <= '0;
      mem_en_q     <= 1'b0;
      mem_addr_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wa_q         <= wa_d;
      off_q        <= off_d;
      funct3_q     <= funct3_d;
      cross_q      <= cross_d;
      lo_q         <= lo_d;
      mem_en_q     <= mem_en_d;
      mem_addr_q   <= mem_addr_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = rst_n && (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign mem_en     = mem_en_q;
  assign mem_addr   = mem_addr_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_load_extract_unit.sv
// Self-checking bench for load_extract_unit against a byte-wise little-endian load model.
module tb_load_extract_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush;
  logic        req_valid, req_valid1;
  logic [31:0] req_addr, req_addr1;
  logic [2:0]  req_funct3, req_funct3_1;

  logic        req_ready, mem_en, resp_valid, resp_err, busy;
  logic [13:0] mem_addr;
  logic [31:0] mem_dout, resp_data;

  logic        req_ready1, mem_en1, resp_valid1, resp_err1, busy1;
  logic [13:0] mem_addr1;
  logic [31:0] mem_dout1, resp_data1;

  logic [31:0] mem [0:16383];

  int n_tests = 0;
  int n_fail  = 0;

  load_extract_unit #(.ADDR_W(14), .MISALIGN_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_funct3(req_funct3),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err), .busy(busy)
  );

  load_extract_unit #(.ADDR_W(14), .MISALIGN_EN(1'b0)) dut_nomis (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_addr(req_addr1), .req_funct3(req_funct3_1),
    .mem_en(mem_en1), .mem_addr(mem_addr1), .mem_dout(mem_dout1),
    .resp_valid(resp_valid1), .resp_data(resp_data1), .resp_err(resp_err1), .busy(busy1)
  );

  always @(posedge clk) begin
    if (mem_en)  mem_dout  <= mem[mem_addr];
    if (mem_en1) mem_dout1 <= mem[mem_addr1];
  end

  // ---------------- reference model ----------------
  function automatic int load_size(input logic [2:0] f);
    if (f[1:0] == 2'd0) return 1;
    if (f[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic logic model_legal(input logic [2:0] f);
    return (f == 3'd0) || (f == 3'd1) || (f == 3'd2) || (f == 3'd4) || (f == 3'd5);
  endfunction

  function automatic logic model_cross(input logic [31:0] a, input logic [2:0] f);
    return (int'(a[1:0]) + load_size(f)) > 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f);
    int          size;
    logic [31:0] v, ba, w;
    size = load_size(f);
    v = 32'h0;
    for (int i = 0; i < size; i++) begin
      ba = a + 32'(i);
      w  = mem[ba[15:2]];
      v[8*i +: 8] = w[8*ba[1:0] +: 8];
    end
    if (!f[2] && size < 4 && v[8*size-1]) v = v | ~((32'h1 << (8*size)) - 32'h1);
    return v;
  endfunction

  // Issues one load to the main DUT and observes an 8-cycle window after the accept edge.
  task automatic issue(input logic [31:0] a, input logic [2:0] f,
                       output int lat, output logic [31:0] d, output logic e,
                       output int nv, output int n_rd,
                       output logic [13:0] ra0, output logic [13:0] ra1);
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_funct3 = f;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = -1; d = 32'h0; e = 1'b0; nv = 0; n_rd = 0; ra0 = '0; ra1 = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (mem_en) begin
        if (n_rd == 0) ra0 = mem_addr; else ra1 = mem_addr;
        n_rd++;
      end
      if (resp_valid) begin
        nv++;
        if (lat < 0) begin lat = k; d = resp_data; e = resp_err; end
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; req_valid1 = 1'b0;
    req_addr = '0; req_funct3 = '0; req_addr1 = '0; req_funct3_1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_tests++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en got=%b exp=0", mem_en); end
    n_tests++; if (mem_addr !== 14'h0) begin n_fail++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    n_tests++; if (resp_data !== 32'h0) begin n_fail++; $display("FAIL reset_resp_data got=%h exp=0", resp_data); end
    n_tests++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_resp_err got=%b exp=0", resp_err); end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++; if (req_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_ready got=%b/%b exp=1/0", req_ready, busy); end
  endtask

  task automatic test_lw_aligned();
    int lat, nv, nr; logic [31:0] d; logic e; logic [13:0] r0, r1;
    mem[4] = 32'hDEADBEEF;
    issue(32'h0000_0010, 3'b010, lat, d, e, nv, nr, r0, r1);
    n_tests++; if (nr != 1 || r0 !== 14'd4) begin n_fail++; $display("FAIL lw_reads got=%0d@%h exp=1@4", nr, r0); end
    n_tests++; if (lat != 3) begin n_fail++; $display("FAIL lw_latency got=%0d exp=3", lat); end
    n_tests++; if (d !== 32'hDEADBEEF || e !== 1'b0) begin n_fail++; $display("FAIL lw_data got=%h/%b exp=deadbeef/0", d, e); end
    n_tests++; if (nv != 1) begin n_fail++; $display("FAIL lw_strobe got=%0d exp=1", nv); end
  endtask

  task automatic test_byte_ext();
    int lat, nv, nr; logic [31:0] d; logic e; logic [13:0] r0, r1;
    mem[4] = 32'h80FF_1234;
    issue(32'h13, 3'b000, lat, d, e, nv, nr, r0, r1);
    n_tests++; if (d !== 32'hFFFF_FF80 || lat != 3) begin n_fail++; $display("FAIL lb_sign got=%h lat=%0d exp=ffffff80 lat=3", d, lat); end
    issue(32'h13, 3'b100, lat, d, e, nv, nr, r0, r1);
    n_tests++; if (d !== 32'h0000_0080 || lat != 3) begin n_fail++; $display("FAIL lbu_zero got=%h lat=%0d exp=00000080 lat=3", d, lat); end
    issue(32'h12, 3'b101, lat, d, e, nv, nr, r0, r1);
    n_tests++; if (d !== 32'h0000_80FF) begin n_fail++; $display("FAIL lhu_zero got=%h exp=000080ff", d); end
  endtask

  task automatic test_cross_lh();
    int lat, nv, nr; logic [31:0] d; logic e; logic [13:0] r0, r1;
    mem[3] = 32'hAB00_0000; mem[4] = 32'h0000_00CD;
    issue(32'h0F, 3'b001, lat, d, e, nv, nr, r0, r1);
    n_tests++; if (nr != 2 || r0 !== 14'd3 || r1 !== 14'd4) begin n_fail++; $display("FAIL lh_cross_reads got=%0d %h %h exp=2 3 4", nr, r0, r1); end
    n_tests++; if (lat != 4) begin n_fail++; $display("FAIL lh_cross_latency got=%0d exp=4", lat); end
    n_tests++; if (d !== 32'hFFFF_CDAB || e !== 1'b0) begin n_fail++; $display("FAIL lh_cross_data got=%h/%b exp=ffffcdab/0", d, e); end
  endtask

  task automatic test_nomisalign();
    int lat, nm, nv; logic [31:0] d; logic e;
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      req_valid1 = 1'b1;
      req_addr1 = (t == 0) ? 32'h0F : 32'h10;
      req_funct3_1 = (t == 0) ? 3'b001 : 3'b010;
      @(posedge clk);
      #1 req_valid1 = 1'b0;
      lat = -1; nm = 0; nv = 0; d = 32'h0; e = 1'b0;
      for (int k = 1; k <= 6; k++) begin
        @(negedge clk);
        if (mem_en1) nm++;
        if (resp_valid1) begin
          nv++;
          if (lat < 0) begin lat = k; d = resp_data1; e = resp_err1; end
        end
      end
      if (t == 0) begin
        n_tests++; if (nm != 0) begin n_fail++; $display("FAIL nomis_no_read got=%0d exp=0", nm); end
        n_tests++; if (lat != 2 || e !== 1'b1 || d !== 32'h0 || nv != 1) begin
          n_fail++; $display("FAIL nomis_err got lat=%0d err=%b data=%h nv=%0d exp lat=2 err=1 data=0 nv=1", lat, e, d, nv); end
      end else begin
        n_tests++; if (lat != 3 || e !== 1'b0 || d !== mem[4]) begin
          n_fail++; $display("FAIL nomis_aligned got lat=%0d err=%b data=%h exp lat=3 err=0 data=%h", lat, e, d, mem[4]); end
      end
    end
  endtask

  task automatic test_wrap();
    int lat, nv, nr; logic [31:0] d, exp_d; logic e; logic [13:0] r0, r1;
    mem[14'h3FFF] = $urandom; mem[0] = $urandom;
    exp_d = model_load(32'h0000_FFFE, 3'b010);
    issue(32'h0000_FFFE, 3'b010, lat, d, e, nv, nr, r0, r1);
    n_tests++; if (nr != 2 || r0 !== 14'h3FFF || r1 !== 14'h0000) begin n_fail++; $display("FAIL wrap_reads got=%0d %h %h exp=2 3fff 0000", nr, r0, r1); end
    n_tests++; if (d !== exp_d || lat != 4) begin n_fail++; $display("FAIL wrap_data got=%h lat=%0d exp=%h lat=4", d, lat, exp_d); end
  endtask

  task automatic test_illegal();
    int lat, nv, nr; logic [31:0] d; logic e; logic [13:0] r0, r1;
    issue(32'h10, 3'b011, lat, d, e, nv, nr, r0, r1);
    n_tests++; if (nr != 0) begin n_fail++; $display("FAIL illegal_no_read got=%0d exp=0", nr); end
    n_tests++; if (lat != 2 || e !== 1'b1 || d !== 32'h0 || nv != 1) begin
      n_fail++; $display("FAIL illegal_err got lat=%0d err=%b data=%h nv=%0d exp lat=2 err=1 data=0 nv=1", lat, e, d, nv); end
  endtask

  task automatic test_busy_ignore();
    int nv; logic [31:0] first_d;
    mem[9] = 32'h1357_9BDF; mem[10] = 32'h2468_ACE0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h24; req_funct3 = 3'b010;
    @(posedge clk);
    #1 req_addr = 32'h28;
    @(negedge clk);
    n_tests++; if (busy !== 1'b1 || req_ready !== 1'b0) begin n_fail++; $display("FAIL busy_flag got=%b/%b exp=1/0", busy, req_ready); end
    req_valid = 1'b0;
    nv = 0; first_d = 32'h0;
    for (int k = 2; k <= 7; k++) begin
      @(negedge clk);
      if (resp_valid) begin if (nv == 0) first_d = resp_data; nv++; end
    end
    n_tests++; if (nv != 1 || first_d !== 32'h1357_9BDF) begin n_fail++; $display("FAIL busy_ignore got nv=%0d data=%h exp nv=1 data=13579bdf", nv, first_d); end
  endtask

  task automatic test_flush();
    int lat, nv, nr, nm; logic [31:0] d, held; logic e; logic [13:0] r0, r1;
    mem[8] = 32'hCAFE_F00D; mem[12] = 32'h0BAD_0BAD;
    issue(32'h20, 3'b010, lat, d, e, nv, nr, r0, r1);
    held = 32'hCAFE_F00D;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h30; req_funct3 = 3'b010;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_tests++; if (req_ready !== 1'b1 || mem_en !== 1'b0 || resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_rd0 got ready=%b mem_en=%b rv=%b exp 1 0 0", req_ready, mem_en, resp_valid); end
    nv = 0;
    for (int k = 0; k < 5; k++) begin @(negedge clk); if (resp_valid) nv++; end
    n_tests++; if (nv != 0 || resp_data !== held) begin n_fail++; $display("FAIL flush_no_resp got nv=%0d data=%h exp nv=0 data=%h", nv, resp_data, held); end
    @(negedge clk);
    req_valid = 1'b1; flush = 1'b1; req_addr = 32'h30; req_funct3 = 3'b010;
    @(posedge clk);
    #1 begin req_valid = 1'b0; flush = 1'b0; end
    nv = 0; nm = 0;
    for (int k = 0; k < 5; k++) begin @(negedge clk); if (resp_valid) nv++; if (mem_en) nm++; end
    n_tests++; if (nv != 0 || nm != 0) begin n_fail++; $display("FAIL flush_idle_drop got nv=%0d reads=%0d exp 0 0", nv, nm); end
  endtask

  task automatic test_reset_mid();
    int nv;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h41; req_funct3 = 3'b010;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_tests++; if ({req_ready, busy, mem_en, resp_valid, resp_err} !== 5'b0 || mem_addr !== 14'h0 || resp_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_mid got rdy=%b busy=%b en=%b addr=%h rv=%b data=%h err=%b exp all 0",
                         req_ready, busy, mem_en, mem_addr, resp_valid, resp_data, resp_err); end
    rst_n = 1'b1;
    nv = 0;
    for (int k = 0; k < 5; k++) begin @(negedge clk); if (resp_valid) nv++; end
    n_tests++; if (nv != 0) begin n_fail++; $display("FAIL reset_mid_no_resp got=%0d exp=0", nv); end
  endtask

  task automatic test_random();
    int lat, nv, nr, exp_lat, exp_nr;
    logic [31:0] a, d, exp_d; logic e, exp_e; logic [2:0] f; logic [13:0] r0, r1, w0;
    logic [2:0] codes [7];
    codes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd7};
    for (int n = 0; n < 40; n++) begin
      a = $urandom;
      f = codes[$urandom_range(0, 6)];
      w0 = a[15:2];
      exp_e = !model_legal(f);
      exp_d = exp_e ? 32'h0 : model_load(a, f);
      exp_lat = exp_e ? 2 : (model_cross(a, f) ? 4 : 3);
      exp_nr  = exp_e ? 0 : (model_cross(a, f) ? 2 : 1);
      issue(a, f, lat, d, e, nv, nr, r0, r1);
      n_tests++;
      if (lat != exp_lat || d !== exp_d || e !== exp_e || nv != 1 || nr != exp_nr
          || (nr > 0 && r0 !== w0) || (nr > 1 && r1 !== w0 + 14'd1)) begin
        n_fail++;
        $display("FAIL rand_load a=%h f=%0d got lat=%0d data=%h err=%b nv=%0d rd=%0d exp lat=%0d data=%h err=%b nv=1 rd=%0d",
                 a, f, lat, d, e, nv, nr, exp_lat, exp_d, exp_e, exp_nr);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = $urandom;
    test_reset();
    test_lw_aligned();
    test_byte_ext();
    test_cross_lh();
    test_nomisalign();
    test_wrap();
    test_illegal();
    test_busy_ignore();
    test_flush();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
